tl45_memory: RTL and testbench

Memory stage of the tl45 pipeline. It sits between execute and writeback.
Register moves pass through in one cycle. Loads and stores run as a Wishbone pipelined single-transfer master cycle while the pipeline is held off.
Its registered destination/value pair feeds writeback's buffer inputs and is also exported as a forwarding source.

---
 rtl/tl45_mem_pkg.sv | 49 ++++
 rtl/tl45_mem_lane.sv | 41 ++++
 rtl/tl45_memory.sv | 206 ++++++++++++++++++++
 tb/tb_tl45_memory.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl45_mem_pkg.sv
// tl45_mem_pkg: shared types and helpers for the tl45 memory stage.
//   mop_t    - memory operation encoding as carried in the execute buffer
//   state_t  - bus-cycle sequencer states
//   decode_mop / is_load / is_store / is_word - operation classification
package tl45_mem_pkg;

    typedef enum logic [2:0] {
        MopNone = 3'b000,
        MopLw   = 3'b001,
        MopLb   = 3'b010,
        MopLbu  = 3'b011,
        MopSw   = 3'b100,
        MopSb   = 3'b101
    } mop_t;

    typedef enum logic [1:0] {
        StIdle,
        StStrobe,
        StWaitAck,
        StDone
    } state_t;

    // Unused encodings (110, 111) behave as "no memory operation".
    function automatic mop_t decode_mop(input logic [2:0] raw);
        mop_t m;
        case (raw)
            3'b001:  m = MopLw;
            3'b010:  m = MopLb;
            3'b011:  m = MopLbu;
            3'b100:  m = MopSw;
            3'b101:  m = MopSb;
            default: m = MopNone;
        endcase
        return m;
    endfunction

    function automatic logic is_load(input mop_t m);
        return (m == MopLw) || (m == MopLb) || (m == MopLbu);
    endfunction

    function automatic logic is_store(input mop_t m);
        return (m == MopSw) || (m == MopSb);
    endfunction

    function automatic logic is_word(input mop_t m);
        return (m == MopLw) || (m == MopSw);
    endfunction

endpackage

// File: rtl/tl45_mem_lane.sv
// tl45_mem_lane: combinational byte-lane handling for the memory stage.
//   i_mop       latched memory operation
//   i_byte_off  byte address bits [1:0]
//   i_st_data   store data from the register file
//   i_rd_data   Wishbone read data
//   o_sel       Wishbone byte-lane select
//   o_wr_data   Wishbone write data (byte stores replicated on every lane)
//   o_ld_val    load result, byte loads sign- or zero-extended
module tl45_mem_lane
    import tl45_mem_pkg::*;
(
    input  mop_t        i_mop,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_rd_data,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wr_data,
    output logic [31:0] o_ld_val
);

    logic [7:0] lane;

    always_comb begin
        lane      = i_rd_data[{i_byte_off, 3'b000} +: 8];
        o_sel     = 4'b1111;
        o_wr_data = i_st_data;
        o_ld_val  = i_rd_data;

        if (!is_word(i_mop)) begin
            o_sel = 4'b0001 << i_byte_off;
        end

        unique case (i_mop)
            MopSb:   o_wr_data = {4{i_st_data[7:0]}};
            MopLb:   o_ld_val  = {{24{lane[7]}}, lane};
            MopLbu:  o_ld_val  = {24'd0, lane};
            default: ;
        endcase
    end

endmodule

// File: rtl/tl45_memory.sv
// tl45_memory: memory stage of the tl45 pipeline (between execute and writeback).
//   i_clk, i_reset          clock; asynchronous active-low reset
//   o_pipe_stall            hold execute while busy or while writeback stalls
//   i_pipe_stall            writeback stall: hold o_buf_*
//   i_buf_mop/dr/val/sr_val execute buffer: operation, dest reg, ALU result, store data
//   o_buf_dr/val            registered result to writeback
//   o_fwd_reg/val           forwarding copy of o_buf_dr/val
//   o_wb_*, i_wb_*          Wishbone pipelined master, one transfer per cycle
//   o_bus_err               one-cycle pulse on a bus error response
//   o_misaligned            one-cycle pulse on a misaligned word access
module tl45_memory
    import tl45_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 30
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_pipe_stall,
    input  logic              i_pipe_stall,
    input  logic [2:0]        i_buf_mop,
    input  logic [3:0]        i_buf_dr,
    input  logic [31:0]       i_buf_val,
    input  logic [31:0]       i_buf_sr_val,
    output logic [3:0]        o_buf_dr,
    output logic [31:0]       o_buf_val,
    output logic [3:0]        o_fwd_reg,
    output logic [31:0]       o_fwd_val,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [31:0]       o_wb_data,
    output logic [3:0]        o_wb_sel,
    input  logic              i_wb_ack,
    input  logic              i_wb_stall,
    input  logic              i_wb_err,
    input  logic [31:0]       i_wb_data,
    output logic              o_bus_err,
    output logic              o_misaligned
);

    state_t      state_q, state_d;
    mop_t        mop_q, mop_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [3:0]  dr_q, dr_d;
    logic [3:0]  res_dr_q, res_dr_d;
    logic [31:0] res_val_q, res_val_d;
    logic [3:0]  buf_dr_q, buf_dr_d;
    logic [31:0] buf_val_q, buf_val_d;
    logic        bus_err_q, bus_err_d;
    logic        misaligned_q, misaligned_d;

    logic        busy;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] lane_ld_val;

    tl45_mem_lane u_lane (
        .i_mop      (mop_q),
        .i_byte_off (addr_q[1:0]),
        .i_st_data  (sdata_q),
        .i_rd_data  (i_wb_data),
        .o_sel      (lane_sel),
        .o_wr_data  (lane_wdata),
        .o_ld_val   (lane_ld_val)
    );

    always_comb begin
        mop_t        in_mop;
        logic        complete;
        logic [3:0]  cmp_dr;
        logic [31:0] cmp_val;

        state_d      = state_q;
        mop_d        = mop_q;
        addr_d       = addr_q;
        sdata_d      = sdata_q;
        dr_d         = dr_q;
        res_dr_d     = res_dr_q;
        res_val_d    = res_val_q;
        buf_dr_d     = buf_dr_q;
        buf_val_d    = buf_val_q;
        bus_err_d    = 1'b0;
        misaligned_d = 1'b0;
        complete     = 1'b0;
        in_mop       = decode_mop(i_buf_mop);

        unique case (state_q)
            StIdle: begin
                if (!i_pipe_stall) begin
                    if (!is_load(in_mop) && !is_store(in_mop)) begin
                        buf_dr_d  = i_buf_dr;
                        buf_val_d = i_buf_val;
                    end else if (is_word(in_mop) && (i_buf_val[1:0] != 2'b00)) begin
                        buf_dr_d     = 4'd0;
                        buf_val_d    = 32'd0;
                        misaligned_d = 1'b1;
                    end else begin
                        // Bubble into writeback while the bus cycle runs.
                        mop_d     = in_mop;
                        addr_d    = i_buf_val;
                        sdata_d   = i_buf_sr_val;
                        dr_d      = i_buf_dr;
                        buf_dr_d  = 4'd0;
                        buf_val_d = 32'd0;
                        state_d   = StStrobe;
                    end
                end
            end
            StStrobe: begin
                if (i_wb_err) begin
                    buf_dr_d  = 4'd0;
                    buf_val_d = 32'd0;
                    bus_err_d = 1'b1;
                    state_d   = StIdle;
                end else if (!i_wb_stall) begin
                    // A slave may acknowledge in the same cycle it accepts the strobe.
                    if (i_wb_ack) begin
                        complete = 1'b1;
                    end else begin
                        state_d = StWaitAck;
                    end
                end
            end
            StWaitAck: begin
                if (i_wb_err) begin
                    buf_dr_d  = 4'd0;
                    buf_val_d = 32'd0;
                    bus_err_d = 1'b1;
                    state_d   = StIdle;
                end else if (i_wb_ack) begin
                    complete = 1'b1;
                end
            end
            StDone: begin
                if (!i_pipe_stall) begin
                    buf_dr_d  = res_dr_q;
                    buf_val_d = res_val_q;
                    state_d   = StIdle;
                end
            end
        endcase

        cmp_dr  = is_load(mop_q) ? dr_q : 4'd0;
        cmp_val = is_load(mop_q) ? lane_ld_val : 32'd0;
        if (complete) begin
            if (i_pipe_stall) begin
                res_dr_d  = cmp_dr;
                res_val_d = cmp_val;
                state_d   = StDone;
            end else begin
                buf_dr_d  = cmp_dr;
                buf_val_d = cmp_val;
                state_d   = StIdle;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= StIdle;
            mop_q        <= MopNone;
            addr_q       <= 32'd0;
            sdata_q      <= 32'd0;
            dr_q         <= 4'd0;
            res_dr_q     <= 4'd0;
            res_val_q    <= 32'd0;
            buf_dr_q     <= 4'd0;
            buf_val_q    <= 32'd0;
            bus_err_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mop_q        <= mop_d;
            addr_q       <= addr_d;
            sdata_q      <= sdata_d;
            dr_q         <= dr_d;
            res_dr_q     <= res_dr_d;
            res_val_q    <= res_val_d;
            buf_dr_q     <= buf_dr_d;
            buf_val_q    <= buf_val_d;
            bus_err_q    <= bus_err_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Bus controls decode straight from state so reset drops cyc/stb immediately.
    always_comb begin
        busy         = (state_q == StStrobe) || (state_q == StWaitAck);
        o_pipe_stall = i_pipe_stall || (state_q != StIdle);
        o_wb_cyc     = busy;
        o_wb_stb     = (state_q == StStrobe);
        o_wb_we      = busy && is_store(mop_q);
        o_wb_addr    = busy ? addr_q[ADDR_W+1:2] : '0;
        o_wb_sel     = busy ? lane_sel : 4'd0;
        o_wb_data    = (busy && is_store(mop_q)) ? lane_wdata : 32'd0;
        o_buf_dr     = buf_dr_q;
        o_buf_val    = buf_val_q;
        o_fwd_reg    = buf_dr_q;
        o_fwd_val    = buf_val_q;
        o_bus_err    = bus_err_q;
        o_misaligned = misaligned_q;
    end

endmodule

// File: tb/tb_tl45_memory.sv
// tb_tl45_memory: randomized self-checking bench for tl45_memory with a
// transaction-level expectation model and a per-cycle compare process.
module tb_tl45_memory;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        o_pipe_stall;
    logic        i_pipe_stall;
    logic [2:0]  i_buf_mop;
    logic [3:0]  i_buf_dr;
    logic [31:0] i_buf_val;
    logic [31:0] i_buf_sr_val;
    logic [3:0]  o_buf_dr;
    logic [31:0] o_buf_val;
    logic [3:0]  o_fwd_reg;
    logic [31:0] o_fwd_val;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [29:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack, i_wb_stall, i_wb_err;
    logic [31:0] i_wb_data;
    logic        o_bus_err, o_misaligned;

    tl45_memory #(.ADDR_W(30)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .o_pipe_stall (o_pipe_stall),
        .i_pipe_stall (i_pipe_stall),
        .i_buf_mop    (i_buf_mop),
        .i_buf_dr     (i_buf_dr),
        .i_buf_val    (i_buf_val),
        .i_buf_sr_val (i_buf_sr_val),
        .o_buf_dr     (o_buf_dr),
        .o_buf_val    (o_buf_val),
        .o_fwd_reg    (o_fwd_reg),
        .o_fwd_val    (o_fwd_val),
        .o_wb_cyc     (o_wb_cyc),
        .o_wb_stb     (o_wb_stb),
        .o_wb_we      (o_wb_we),
        .o_wb_addr    (o_wb_addr),
        .o_wb_data    (o_wb_data),
        .o_wb_sel     (o_wb_sel),
        .i_wb_ack     (i_wb_ack),
        .i_wb_stall   (i_wb_stall),
        .i_wb_err     (i_wb_err),
        .i_wb_data    (i_wb_data),
        .o_bus_err    (o_bus_err),
        .o_misaligned (o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected observable state after the most recent rising edge.
    bit          chk_en = 1'b0;
    logic [3:0]  exp_dr;
    logic [31:0] exp_val;
    bit          exp_val_known;
    bit          exp_busy, exp_cyc, exp_stb, exp_we, exp_mis, exp_err;
    logic [29:0] exp_addr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdata;

    // Last strobe seen on the bus, for literal pins.
    logic [29:0] seen_addr;
    logic [3:0]  seen_sel;
    logic [31:0] seen_wdata;
    logic        seen_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge i_clk);
        #1;
        if (chk_en) begin
            check("buf_dr", 32'(o_buf_dr), 32'(exp_dr));
            check("fwd_reg", 32'(o_fwd_reg), 32'(exp_dr));
            if (exp_val_known) begin
                check("buf_val", o_buf_val, exp_val);
                check("fwd_val", o_fwd_val, exp_val);
            end
            check("pipe_stall", 32'(o_pipe_stall), 32'(i_pipe_stall | exp_busy));
            check("wb_cyc", 32'(o_wb_cyc), 32'(exp_cyc));
            check("wb_stb", 32'(o_wb_stb), 32'(exp_stb));
            check("misaligned", 32'(o_misaligned), 32'(exp_mis));
            check("bus_err", 32'(o_bus_err), 32'(exp_err));
            if (exp_cyc) check("wb_we", 32'(o_wb_we), 32'(exp_we));
            if (exp_stb) begin
                check("wb_addr", 32'(o_wb_addr), 32'(exp_addr));
                check("wb_sel", 32'(o_wb_sel), 32'(exp_sel));
                if (exp_we) check("wb_data", o_wb_data, exp_wdata);
                seen_addr  = o_wb_addr;
                seen_sel   = o_wb_sel;
                seen_wdata = o_wb_data;
                seen_we    = o_wb_we;
            end
        end
    end

    // Advance one edge; pulses last exactly one cycle.
    task automatic tick();
        @(posedge i_clk);
        exp_mis = 1'b0;
        exp_err = 1'b0;
    endtask

    // Junk on every input the DUT must ignore while busy; no bus response.
    task automatic scramble();
        i_buf_mop    = 3'($urandom);
        i_buf_dr     = 4'($urandom);
        i_buf_val    = $urandom;
        i_buf_sr_val = $urandom;
        i_wb_data    = $urandom;
        i_wb_ack     = 1'b0;
        i_wb_err     = 1'b0;
        i_wb_stall   = 1'b0;
    endtask

    function automatic logic [31:0] load_result(input logic [2:0] mop, input logic [31:0] addr,
                                                input logic [31:0] rdata);
        int unsigned b;
        b = (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
        if (mop == 3'd1) return rdata;
        if (mop == 3'd2 && b >= 128) return 32'(b - 256);
        return 32'(b);
    endfunction

    // One execute-buffer operation: nstall strobe-stall cycles, nwait cycles from strobe
    // acceptance to response, optional error response, npend writeback-stall cycles at completion.
    task automatic do_op(input logic [2:0] mop, input logic [3:0] dr, input logic [31:0] addr,
                         input logic [31:0] sr, input logic [31:0] rdata, input int nstall,
                         input int nwait, input bit err, input int npend);
        bit          load, store, word;
        logic [3:0]  res_dr;
        logic [31:0] res_val;
        load  = (mop >= 3'd1 && mop <= 3'd3);
        store = (mop == 3'd4 || mop == 3'd5);
        word  = (mop == 3'd1 || mop == 3'd4);

        @(negedge i_clk);
        scramble();
        i_buf_mop    = mop;
        i_buf_dr     = dr;
        i_buf_val    = addr;
        i_buf_sr_val = sr;
        i_pipe_stall = 1'b0;
        tick();
        if (!load && !store) begin
            exp_dr        = dr;
            exp_val       = addr;
            exp_val_known = 1'b1;
            return;
        end
        exp_dr        = 4'd0;
        exp_val_known = 1'b0;
        if (word && addr[1:0] != 2'b00) begin
            exp_mis = 1'b1;
            return;
        end
        exp_busy  = 1'b1;
        exp_cyc   = 1'b1;
        exp_stb   = 1'b1;
        exp_we    = store;
        exp_addr  = 30'(addr >> 2);
        exp_sel   = word ? 4'hF : 4'(1 << addr[1:0]);
        exp_wdata = (mop == 3'd4) ? sr : 32'(sr[7:0]) * 32'h01010101;

        for (int i = 0; i < nstall; i++) begin
            @(negedge i_clk);
            scramble();
            i_wb_stall   = 1'b1;
            i_pipe_stall = 1'($urandom);
            tick();
        end

        @(negedge i_clk);
        scramble();
        i_pipe_stall = 1'($urandom);
        if (nwait == 0) begin
            i_pipe_stall = !err && (npend > 0);
            if (err) begin
                i_wb_err = 1'b1;
                i_wb_ack = 1'($urandom);
            end else begin
                i_wb_ack  = 1'b1;
                i_wb_data = rdata;
            end
        end
        tick();
        if (nwait > 0) begin
            exp_stb = 1'b0;
            for (int i = 1; i < nwait; i++) begin
                @(negedge i_clk);
                scramble();
                i_wb_stall   = 1'($urandom);
                i_pipe_stall = 1'($urandom);
                tick();
            end
            @(negedge i_clk);
            scramble();
            i_pipe_stall = !err && (npend > 0);
            if (err) begin
                i_wb_err = 1'b1;
                i_wb_ack = 1'($urandom);
            end else begin
                i_wb_ack  = 1'b1;
                i_wb_data = rdata;
            end
            tick();
        end

        exp_cyc = 1'b0;
        exp_stb = 1'b0;
        if (err) begin
            exp_busy = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        res_dr  = load ? dr : 4'd0;
        res_val = load_result(mop, addr, rdata);
        if (npend > 0) begin
            for (int i = 1; i < npend; i++) begin
                @(negedge i_clk);
                scramble();
                i_pipe_stall = 1'b1;
                tick();
            end
            @(negedge i_clk);
            scramble();
            i_pipe_stall = 1'b0;
            tick();
        end
        exp_busy      = 1'b0;
        exp_dr        = res_dr;
        exp_val       = res_val;
        exp_val_known = load;
    endtask

    task automatic idle_stall();
        @(negedge i_clk);
        scramble();
        i_pipe_stall = 1'b1;
        tick();
    endtask

    task automatic reset_mid_wait();
        do_op_start_wait();
        #2;
        i_reset = 1'b0;
        exp_dr = 4'd0; exp_val = 32'd0; exp_val_known = 1'b1;
        exp_busy = 1'b0; exp_cyc = 1'b0; exp_stb = 1'b0;
        exp_mis = 1'b0; exp_err = 1'b0;
        #1;
        check("rst_async_cyc", 32'(o_wb_cyc), 32'd0);
        check("rst_async_buf_dr", 32'(o_buf_dr), 32'd0);
        check("rst_async_stall", 32'(o_pipe_stall), 32'd0);
        @(negedge i_clk);
        tick();
        @(negedge i_clk);
        i_reset      = 1'b1;
        i_pipe_stall = 1'b1;
        i_wb_ack     = 1'b1;
        i_wb_data    = 32'hCAFEF00D;
        tick();
        #2;
        check("late_ack_buf_dr", 32'(o_buf_dr), 32'd0);
        check("late_ack_buf_val", o_buf_val, 32'd0);
    endtask

    // LW at 0x200 into WAIT_ACK with no response yet.
    task automatic do_op_start_wait();
        @(negedge i_clk);
        scramble();
        i_buf_mop = 3'd1; i_buf_dr = 4'd5; i_buf_val = 32'h200; i_pipe_stall = 1'b0;
        tick();
        exp_dr = 4'd0; exp_val_known = 1'b0;
        exp_busy = 1'b1; exp_cyc = 1'b1; exp_stb = 1'b1; exp_we = 1'b0;
        exp_addr = 30'h80; exp_sel = 4'hF;
        @(negedge i_clk);
        scramble();
        i_pipe_stall = 1'b0;
        tick();
        exp_stb = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  mop;
        logic [31:0] addr;
        int          nst, nwt, np;
        bit          er;

        i_reset = 1'b0; i_pipe_stall = 1'b0;
        i_buf_mop = 3'd0; i_buf_dr = 4'd0; i_buf_val = 32'd0; i_buf_sr_val = 32'd0;
        i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_err = 1'b0; i_wb_data = 32'd0;
        exp_dr = 4'd0; exp_val = 32'd0; exp_val_known = 1'b1;
        exp_busy = 1'b0; exp_cyc = 1'b0; exp_stb = 1'b0; exp_we = 1'b0;
        exp_mis = 1'b0; exp_err = 1'b0; exp_addr = '0; exp_sel = '0; exp_wdata = '0;
        seen_addr = '0; seen_sel = '0; seen_wdata = '0; seen_we = 1'b0;
        #3;
        check("reset_buf_dr", 32'(o_buf_dr), 32'd0);
        check("reset_buf_val", o_buf_val, 32'd0);
        check("reset_cyc", 32'(o_wb_cyc), 32'd0);
        check("reset_stall", 32'(o_pipe_stall), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        chk_en  = 1'b1;

        do_op(3'd0, 4'd3, 32'h1234, 32'd0, 32'd0, 0, 0, 1'b0, 0);
        #2;
        check("pin_pass_dr", 32'(o_buf_dr), 32'd3);
        check("pin_pass_val", o_buf_val, 32'h1234);
        check("pin_pass_fwd", o_fwd_val, 32'h1234);

        do_op(3'd1, 4'd4, 32'h1002, 32'd0, 32'd0, 0, 0, 1'b0, 0);
        #2;
        check("pin_mis_pulse", 32'(o_misaligned), 32'd1);
        check("pin_mis_dr", 32'(o_buf_dr), 32'd0);

        do_op(3'd1, 4'd9, 32'h100, 32'd0, 32'hDEADBEEF, 2, 1, 1'b0, 0);
        #2;
        check("pin_lw_addr", 32'(seen_addr), 32'h40);
        check("pin_lw_sel", 32'(seen_sel), 32'hF);
        check("pin_lw_dr", 32'(o_buf_dr), 32'd9);
        check("pin_lw_val", o_buf_val, 32'hDEADBEEF);

        do_op(3'd2, 4'd7, 32'h103, 32'd0, 32'h80000000, 0, 0, 1'b0, 0);
        #2;
        check("pin_lb_val", o_buf_val, 32'hFFFFFF80);
        do_op(3'd3, 4'd7, 32'h103, 32'd0, 32'h80000000, 0, 1, 1'b0, 0);
        #2;
        check("pin_lbu_val", o_buf_val, 32'h00000080);

        do_op(3'd5, 4'd6, 32'h102, 32'h5A, 32'd0, 0, 0, 1'b0, 0);
        #2;
        check("pin_sb_sel", 32'(seen_sel), 32'h4);
        check("pin_sb_data", seen_wdata, 32'h5A5A5A5A);
        check("pin_sb_we", 32'(seen_we), 32'd1);
        check("pin_sb_dr", 32'(o_buf_dr), 32'd0);

        do_op(3'd1, 4'd2, 32'h40, 32'd0, 32'd0, 1, 2, 1'b1, 0);
        #2;
        check("pin_err_pulse", 32'(o_bus_err), 32'd1);
        check("pin_err_dr", 32'(o_buf_dr), 32'd0);

        do_op(3'd1, 4'd11, 32'h80, 32'd0, 32'h13579BDF, 0, 0, 1'b0, 2);
        #2;
        check("pin_done_val", o_buf_val, 32'h13579BDF);

        idle_stall();
        idle_stall();
        reset_mid_wait();

        for (int k = 0; k < 300; k++) begin
            mop  = 3'($urandom);
            addr = $urandom;
            if ((mop == 3'd1 || mop == 3'd4) && $urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            nst = $urandom_range(0, 2);
            nwt = $urandom_range(0, 2);
            er  = ($urandom_range(0, 7) == 0);
            np  = er ? 0 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
            do_op(mop, 4'($urandom), addr, $urandom, $urandom, nst, nwt, er, np);
            if ($urandom_range(0, 4) == 0) idle_stall();
        end
        idle_stall();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
